serial_frame_tx: RTL and testbench

Parallel-to-serial frame transmitter for the flip-flop/register library. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out on a single registered line: a start bit, the data LSB-first, an optional parity bit, then a stop bit. Each bit is held for DIV clocks. A complementary output is driven alongside. It is the transmit end for the team's serial capture/shift-register receivers.

---
 rtl/serial_tx_pkg.sv | 17 +
 rtl/bit_timer.sv | 28 ++
 rtl/serial_frame_tx.sv | 119 +++++++++++
 tb/tb_serial_frame_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter and its matching receiver.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Serial bits per frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int width, input int parity_en);
        return width + 2 + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Divides clk into serial bit periods; tick marks the last clock of each bit.
module bit_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = !clear && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start, data LSB-first, optional parity, stop.
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIV        = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             txd,
    output logic             txd_n,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_shift, w_shift_next;
    logic [BW-1:0]    r_bit_cnt, w_bit_cnt_next;
    logic             r_parity, w_parity_next;
    logic             r_txd, r_txd_n, r_busy;
    logic             w_txd_next;
    logic             w_tick;
    logic             w_accept;
    logic             w_timer_clear;

    assign tx_ready      = (r_state == IDLE);
    assign w_accept      = tx_valid && tx_ready;
    assign w_timer_clear = (r_state == IDLE);

    bit_timer #(
        .DIV(DIV)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(w_timer_clear),
        .tick (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_parity_next  = r_parity;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next   = START;
                    w_shift_next   = tx_data;
                    w_bit_cnt_next = '0;
                    w_parity_next  = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                end
            end
            START: begin
                if (w_tick) w_state_next = DATA;
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) w_state_next = STOP;
            end
            STOP: begin
                if (w_tick) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // The line level is registered from the next state so it lines up with the state it encodes.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = w_shift_next[0];
            PARITY:  w_txd_next = w_parity_next;
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_txd     <= 1'b1;
            r_txd_n   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_parity  <= w_parity_next;
            r_txd     <= w_txd_next;
            r_txd_n   <= ~w_txd_next;
            r_busy    <= (w_state_next != IDLE);
        end
    end

    assign txd   = r_txd;
    assign txd_n = r_txd_n;
    assign busy  = r_busy;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx across four parameter sets sharing one clock and reset.
module tb_serial_frame_tx;
    import serial_tx_pkg::*;

    typedef struct {
        logic txd;
        logic busy;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] valid_v;
    logic [7:0] data_v [4];
    logic [3:0] ready_v, txd_v, txd_n_v, busy_v;

    int   n_checks;
    int   n_fail;
    exp_t sb [$];
    time  acc_t [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_frame_tx u_def (
        .clk(clk), .rst(rst), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
        .tx_ready(ready_v[0]), .txd(txd_v[0]), .txd_n(txd_n_v[0]), .busy(busy_v[0])
    );

    serial_frame_tx #(.PARITY_ODD(1)) u_odd (
        .clk(clk), .rst(rst), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
        .tx_ready(ready_v[1]), .txd(txd_v[1]), .txd_n(txd_n_v[1]), .busy(busy_v[1])
    );

    serial_frame_tx #(.PARITY_EN(0)) u_nop (
        .clk(clk), .rst(rst), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
        .tx_ready(ready_v[2]), .txd(txd_v[2]), .txd_n(txd_n_v[2]), .busy(busy_v[2])
    );

    serial_frame_tx #(.WIDTH(1), .DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .tx_data(data_v[3][0]), .tx_valid(valid_v[3]),
        .tx_ready(ready_v[3]), .txd(txd_v[3]), .txd_n(txd_n_v[3]), .busy(busy_v[3])
    );

    always @(posedge clk) begin
        if (valid_v[0] && ready_v[0]) acc_t.push_back($time);
    end

    // Expected line level per clock for one frame, followed by the idle-high cycle.
    task automatic push_frame(input logic [7:0] d, input int w, input int div,
                              input int pen, input int podd);
        int   n;
        logic p;
        logic b;
        n = frame_bits(w, pen);
        p = 1'b0;
        for (int i = 0; i < w; i++) p = p ^ d[i];
        if (podd != 0) p = ~p;
        for (int k = 0; k < n; k++) begin
            if (k == 0)                           b = 1'b0;
            else if (k <= w)                      b = d[k-1];
            else if ((pen != 0) && (k == w + 1))  b = p;
            else                                  b = 1'b1;
            for (int r = 0; r < div; r++) sb.push_back('{txd: b, busy: 1'b1});
        end
        sb.push_back('{txd: 1'b1, busy: 1'b0});
    endtask

    task automatic accept_word(input int dn, input logic [7:0] d, input logic hold);
        @(negedge clk);
        n_checks++;
        if (ready_v[dn] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready dut%0d: tx_ready=%b required 1", dn, ready_v[dn]);
        end
        data_v[dn]  = d;
        valid_v[dn] = 1'b1;
        @(posedge clk);
        #1;
        valid_v[dn] = hold;
        if (!hold) data_v[dn] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 3) rst = 1'b0;
            n_checks++;
            if (txd_v !== 4'hF || txd_n_v !== 4'h0 || busy_v !== 4'h0 || ready_v !== 4'hF) begin
                n_fail++;
                $display("FAIL reset_state cyc %0d: txd=%b txd_n=%b busy=%b ready=%b required F 0 0 F",
                         c, txd_v, txd_n_v, busy_v, ready_v);
            end
        end
    endtask

    task automatic test_default_frame(input logic [7:0] d);
        exp_t e;
        int   idx;
        push_frame(d, 8, 4, 1, 0);
        accept_word(0, d, 1'b0);
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            n_checks++;
            if (txd_v[0] !== e.txd || txd_n_v[0] !== ~e.txd || busy_v[0] !== e.busy || ready_v[0] !== ~e.busy) begin
                n_fail++;
                $display("FAIL default_frame %h cyc %0d: txd=%b txd_n=%b busy=%b ready=%b required txd=%b busy=%b",
                         d, idx + 1, txd_v[0], txd_n_v[0], busy_v[0], ready_v[0], e.txd, e.busy);
            end
            idx++;
        end
    endtask

    task automatic test_parity_odd();
        exp_t e;
        int   idx;
        push_frame(8'h01, 8, 4, 1, 1);
        accept_word(1, 8'h01, 1'b0);
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            n_checks++;
            if (txd_v[1] !== e.txd || txd_n_v[1] !== ~e.txd || busy_v[1] !== e.busy || ready_v[1] !== ~e.busy) begin
                n_fail++;
                $display("FAIL parity_odd cyc %0d: txd=%b txd_n=%b busy=%b ready=%b required txd=%b busy=%b",
                         idx + 1, txd_v[1], txd_n_v[1], busy_v[1], ready_v[1], e.txd, e.busy);
            end
            idx++;
        end
    endtask

    task automatic test_no_parity();
        exp_t e;
        int   idx;
        push_frame(8'hFF, 8, 4, 0, 0);
        accept_word(2, 8'hFF, 1'b0);
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            n_checks++;
            if (txd_v[2] !== e.txd || txd_n_v[2] !== ~e.txd || busy_v[2] !== e.busy || ready_v[2] !== ~e.busy) begin
                n_fail++;
                $display("FAIL no_parity cyc %0d: txd=%b txd_n=%b busy=%b ready=%b required txd=%b busy=%b",
                         idx + 1, txd_v[2], txd_n_v[2], busy_v[2], ready_v[2], e.txd, e.busy);
            end
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   idx;
        acc_t.delete();
        push_frame(8'h3C, 8, 4, 1, 0);
        push_frame(8'hC3, 8, 4, 1, 0);
        accept_word(0, 8'h3C, 1'b1);
        data_v[0] = 8'hC3;
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            n_checks++;
            if (txd_v[0] !== e.txd || txd_n_v[0] !== ~e.txd || busy_v[0] !== e.busy || ready_v[0] !== ~e.busy) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: txd=%b txd_n=%b busy=%b ready=%b required txd=%b busy=%b",
                         idx + 1, txd_v[0], txd_n_v[0], busy_v[0], ready_v[0], e.txd, e.busy);
            end
            if (idx == 44) begin
                @(posedge clk);
                #1;
                valid_v[0] = 1'b0;
            end
            idx++;
        end
        n_checks++;
        if (acc_t.size() != 2 || (acc_t[1] - acc_t[0]) != 450) begin
            n_fail++;
            $display("FAIL accept_period: accepts=%0d spacing=%0t required 2 accepts 450 apart",
                     acc_t.size(), (acc_t.size() == 2) ? acc_t[1] - acc_t[0] : 0);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   idx;
        accept_word(0, 8'h5A, 1'b0);
        repeat (18) @(negedge clk);
        n_checks++;
        if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_prebit: txd=%b busy=%b required txd=1 busy=1", txd_v[0], busy_v[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (txd_v !== 4'hF || txd_n_v !== 4'h0 || busy_v !== 4'h0 || ready_v !== 4'hF) begin
            n_fail++;
            $display("FAIL async_reset: txd=%b txd_n=%b busy=%b ready=%b required F 0 0 F",
                     txd_v, txd_n_v, busy_v, ready_v);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL no_resend cyc %0d: txd=%b busy=%b ready=%b required 1 0 1",
                         c, txd_v[0], busy_v[0], ready_v[0]);
            end
        end
        push_frame(8'h0F, 8, 4, 1, 0);
        accept_word(0, 8'h0F, 1'b0);
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            n_checks++;
            if (txd_v[0] !== e.txd || txd_n_v[0] !== ~e.txd || busy_v[0] !== e.busy || ready_v[0] !== ~e.busy) begin
                n_fail++;
                $display("FAIL after_abort cyc %0d: txd=%b txd_n=%b busy=%b ready=%b required txd=%b busy=%b",
                         idx + 1, txd_v[0], txd_n_v[0], busy_v[0], ready_v[0], e.txd, e.busy);
            end
            idx++;
        end
    endtask

    task automatic test_div1();
        exp_t e;
        int   idx;
        push_frame(8'h01, 1, 1, 1, 0);
        accept_word(3, 8'h01, 1'b0);
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            n_checks++;
            if (txd_v[3] !== e.txd || txd_n_v[3] !== ~e.txd || busy_v[3] !== e.busy || ready_v[3] !== ~e.busy) begin
                n_fail++;
                $display("FAIL div1 cyc %0d: txd=%b txd_n=%b busy=%b ready=%b required txd=%b busy=%b",
                         idx + 1, txd_v[3], txd_n_v[3], busy_v[3], ready_v[3], e.txd, e.busy);
            end
            idx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        valid_v  = 4'h0;
        for (int i = 0; i < 4; i++) data_v[i] = 8'h00;

        test_reset();
        test_default_frame(8'hA5);
        test_default_frame(8'($urandom));
        test_parity_odd();
        test_no_parity();
        test_back_to_back();
        test_reset_abort();
        test_div1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
